// File: rtl/warp_issue_scheduler.sv
// Round-robin issue scheduler: one eligible warp FIFO head per cycle into a single-entry issue register.
// Latency 1 cycle (eligible in N, on issue_* in N+1); holds its entry and stops popping while issue_ready is low.
module warp_issue_scheduler #(
    parameter int NUM_WARPS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int WID_W      = $clog2(NUM_WARPS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_WARPS-1:0]            fifo_valid,
    input  logic [NUM_WARPS*DATA_WIDTH-1:0] fifo_data,
    output logic [NUM_WARPS-1:0]            fifo_pop,
    input  logic [NUM_WARPS-1:0]            warp_enable,
    input  logic [NUM_WARPS-1:0]            warp_stall,
    output logic                            issue_valid,
    output logic [DATA_WIDTH-1:0]           issue_data,
    output logic [WID_W-1:0]                issue_wid,
    input  logic                            issue_ready,
    input  logic                            halt_req,
    output logic                            halted,
    output logic [15:0]                     issue_count
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [NUM_WARPS-1:0]   elig;
    logic [WID_W-1:0]       last_grant;
    logic [WID_W-1:0]       sel;
    logic                   sel_found;
    logic                   slot_free;
    logic                   select;
    logic                   accept;
    logic [DATA_WIDTH-1:0]  head [NUM_WARPS];

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_head
        assign head[w] = fifo_data[w*DATA_WIDTH +: DATA_WIDTH];
    end

    assign elig      = fifo_valid & warp_enable & ~warp_stall;
    assign accept    = issue_valid & issue_ready;
    assign slot_free = ~issue_valid | issue_ready;
    // halt_req blocks selection in the same cycle RUN moves to DRAIN
    assign select    = rst_n & (state == RUN) & ~halt_req & slot_free & sel_found;

    // NUM_WARPS is a power of two, so the WID_W-bit add wraps the search naturally
    always_comb begin
        logic [WID_W-1:0] idx;
        sel       = '0;
        sel_found = 1'b0;
        idx       = '0;
        for (int i = 1; i <= NUM_WARPS; i++) begin
            idx = last_grant + WID_W'(i);
            if (!sel_found && elig[idx]) begin
                sel_found = 1'b1;
                sel       = idx;
            end
        end
    end

    always_comb begin
        fifo_pop = '0;
        if (select) begin
            fifo_pop[sel] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (halt_req) state_next = DRAIN;
            end
            DRAIN: begin
                if (!halt_req)                      state_next = RUN;
                else if (!issue_valid || issue_ready) state_next = HALTED;
            end
            HALTED: begin
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            halted      <= 1'b0;
            issue_valid <= 1'b0;
            issue_data  <= '0;
            issue_wid   <= '0;
            issue_count <= '0;
            last_grant  <= WID_W'(NUM_WARPS - 1);
        end else begin
            state  <= state_next;
            halted <= (state_next == HALTED);
            if (accept) begin
                issue_count <= issue_count + 16'd1;
            end
            if (select) begin
                issue_valid <= 1'b1;
                issue_data  <= head[sel];
                issue_wid   <= sel;
                last_grant  <= sel;
            end else if (accept) begin
                issue_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Directed bench for warp_issue_scheduler with a small per-warp FIFO model.
module tb_warp_issue_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   fifo_valid;
    logic [127:0] fifo_data;
    logic [3:0]   fifo_pop;
    logic [3:0]   warp_enable;
    logic [3:0]   warp_stall;
    logic         issue_valid;
    logic [31:0]  issue_data;
    logic [1:0]   issue_wid;
    logic         issue_ready;
    logic         halt_req;
    logic         halted;
    logic [15:0]  issue_count;

    int checks = 0;
    int passed = 0;
    int bad_pop = 0;
    bit use_model = 1'b1;

    logic [31:0] mem [4][8];
    int          rd [4];
    int          wr [4];

    warp_issue_scheduler #(.NUM_WARPS(4), .DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fifo_valid  (fifo_valid),
        .fifo_data   (fifo_data),
        .fifo_pop    (fifo_pop),
        .warp_enable (warp_enable),
        .warp_stall  (warp_stall),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .issue_wid   (issue_wid),
        .issue_ready (issue_ready),
        .halt_req    (halt_req),
        .halted      (halted),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    task automatic refresh();
        for (int w = 0; w < 4; w++) begin
            fifo_valid[w] = (rd[w] != wr[w]);
            fifo_data[w*32 +: 32] = mem[w][rd[w] & 7];
        end
    endtask

    task automatic clear_model();
        for (int w = 0; w < 4; w++) begin
            rd[w] = 0;
            wr[w] = 0;
            for (int i = 0; i < 8; i++) mem[w][i] = 32'h0;
        end
        refresh();
    endtask

    task automatic push(input int w, input logic [31:0] d);
        mem[w][wr[w] & 7] = d;
        wr[w] = wr[w] + 1;
        refresh();
    endtask

    // One clock: pops are sampled mid-cycle, inputs/checks happen 1 time unit after the edge
    task automatic step(output logic [3:0] pops);
        @(negedge clk);
        pops = fifo_pop;
        @(posedge clk);
        #1;
        if (use_model) begin
            for (int w = 0; w < 4; w++) begin
                if (pops[w]) begin
                    if (rd[w] == wr[w]) bad_pop++;
                    else rd[w] = rd[w] + 1;
                end
            end
            refresh();
        end
    endtask

    task automatic test_reset();
        logic [3:0] p;
        use_model   = 1'b0;
        rst_n       = 1'b0;
        fifo_valid  = 4'hF;
        warp_enable = 4'hF;
        #1;
        checks++; if (fifo_pop !== 4'h0) $display("FAIL reset_pop got=%h exp=0", fifo_pop); else passed++;
        step(p);
        step(p);
        checks++; if (p !== 4'h0) $display("FAIL reset_pop_edge got=%h exp=0", p); else passed++;
        checks++;
        if ({issue_valid, issue_data, issue_wid, halted, issue_count} !== 52'h0)
            $display("FAIL reset_state valid=%b data=%h wid=%0d halted=%b count=%h exp all 0",
                     issue_valid, issue_data, issue_wid, halted, issue_count);
        else passed++;
        rst_n       = 1'b1;
        warp_enable = 4'h0;
        use_model   = 1'b1;
        clear_model();
        step(p);
    endtask

    task automatic test_round_robin();
        logic [3:0] p;
        clear_model();
        for (int w = 0; w < 4; w++) push(w, 32'hA0 + w);
        for (int w = 0; w < 4; w++) push(w, 32'hB0 + w);
        warp_enable = 4'hF;
        warp_stall  = 4'h0;
        issue_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(p);
            checks++;
            if (p !== 4'(1 << (k % 4)) || issue_valid !== 1'b1 || issue_wid !== 2'(k % 4) ||
                issue_data !== ((k < 4) ? 32'hA0 + k : 32'hB0 + k - 4))
                $display("FAIL rr_%0d pop=%h valid=%b wid=%0d data=%h exp pop=%h wid=%0d", k, p,
                         issue_valid, issue_wid, issue_data, 4'(1 << (k % 4)), k % 4);
            else passed++;
        end
        step(p);
        checks++;
        if (issue_count !== 16'd8 || issue_valid !== 1'b0)
            $display("FAIL rr_count count=%0d valid=%b exp 8/0", issue_count, issue_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        logic [3:0] p;
        clear_model();
        push(3, 32'h1234);
        issue_ready = 1'b0;
        step(p);
        push(3, 32'h9999);
        for (int k = 0; k < 3; k++) begin
            step(p);
            checks++;
            if (p !== 4'h0 || issue_data !== 32'h1234 || issue_wid !== 2'd3 ||
                issue_valid !== 1'b1 || issue_count !== 16'd8)
                $display("FAIL bp_hold_%0d pop=%h data=%h wid=%0d count=%0d exp 0/1234/3/8",
                         k, p, issue_data, issue_wid, issue_count);
            else passed++;
        end
        issue_ready = 1'b1;
        step(p);
        checks++;
        if (issue_data !== 32'h9999 || issue_count !== 16'd9 || issue_valid !== 1'b1)
            $display("FAIL bp_release data=%h count=%0d exp 9999/9", issue_data, issue_count);
        else passed++;
        step(p);
        checks++;
        if (issue_count !== 16'd10 || issue_valid !== 1'b0)
            $display("FAIL bp_drain count=%0d valid=%b exp 10/0", issue_count, issue_valid);
        else passed++;
    endtask

    task automatic test_stall_enable();
        logic [3:0]  p;
        logic [31:0] exp_d [4];
        logic [1:0]  exp_w [4];
        exp_d[0] = 32'h300; exp_d[1] = 32'h330; exp_d[2] = 32'h301; exp_d[3] = 32'h331;
        exp_w[0] = 2'd0;    exp_w[1] = 2'd3;    exp_w[2] = 2'd0;    exp_w[3] = 2'd3;
        clear_model();
        for (int w = 0; w < 4; w++)
            for (int i = 0; i < 4; i++) push(w, 32'h300 + w * 16 + i);
        warp_stall  = 4'b0010;
        warp_enable = 4'b1011;
        issue_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step(p);
            checks++;
            if ((p & 4'b0110) !== 4'h0 || issue_wid !== exp_w[k] || issue_data !== exp_d[k])
                $display("FAIL stall_%0d pop=%h wid=%0d data=%h exp wid=%0d data=%h",
                         k, p, issue_wid, issue_data, exp_w[k], exp_d[k]);
            else passed++;
        end
        warp_enable = 4'h0;
        warp_stall  = 4'h0;
        step(p);
        checks++;
        if (issue_count !== 16'd14 || issue_valid !== 1'b0)
            $display("FAIL stall_count count=%0d valid=%b exp 14/0", issue_count, issue_valid);
        else passed++;
    endtask

    task automatic test_halt();
        logic [3:0] p;
        clear_model();
        push(0, 32'h55);
        warp_enable = 4'hF;
        issue_ready = 1'b0;
        step(p);
        push(1, 32'h66);
        halt_req = 1'b1;
        #1;
        checks++; if (fifo_pop !== 4'h0) $display("FAIL halt_req_pop got=%h exp=0", fifo_pop); else passed++;
        step(p);
        step(p);
        checks++;
        if (p !== 4'h0 || halted !== 1'b0 || issue_data !== 32'h55 || issue_valid !== 1'b1)
            $display("FAIL halt_drain pop=%h halted=%b data=%h exp 0/0/55", p, halted, issue_data);
        else passed++;
        issue_ready = 1'b1;
        step(p);
        checks++;
        if (halted !== 1'b1 || issue_valid !== 1'b0 || issue_count !== 16'd15 || p !== 4'h0)
            $display("FAIL halt_enter halted=%b valid=%b count=%0d pop=%h exp 1/0/15/0",
                     halted, issue_valid, issue_count, p);
        else passed++;
        step(p);
        checks++;
        if (halted !== 1'b1 || p !== 4'h0)
            $display("FAIL halt_hold halted=%b pop=%h exp 1/0", halted, p);
        else passed++;
        halt_req = 1'b0;
        step(p);
        checks++;
        if (halted !== 1'b0 || p !== 4'h0 || issue_valid !== 1'b0)
            $display("FAIL halt_exit halted=%b pop=%h valid=%b exp 0/0/0", halted, p, issue_valid);
        else passed++;
        step(p);
        checks++;
        if (issue_wid !== 2'd1 || issue_data !== 32'h66 || issue_valid !== 1'b1)
            $display("FAIL halt_resume wid=%0d data=%h exp 1/66", issue_wid, issue_data);
        else passed++;
        step(p);
        checks++;
        if (issue_count !== 16'd16) $display("FAIL halt_count got=%0d exp=16", issue_count); else passed++;
    endtask

    task automatic test_wrap_and_reset();
        logic [3:0] p;
        int         bad = 0;
        use_model   = 1'b0;
        fifo_valid  = 4'b0001;
        fifo_data   = {32'h73, 32'h72, 32'h71, 32'h70};
        warp_enable = 4'hF;
        issue_ready = 1'b1;
        // first step only loads, each later one also retires an issue: 16 + 65518 = 0xFFFE
        for (int k = 0; k < 65519; k++) begin
            step(p);
            if (p !== 4'b0001 || issue_wid !== 2'd0 || issue_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) $display("FAIL b2b_single got=%0d bad cycles exp=0", bad); else passed++;
        checks++; if (issue_count !== 16'hFFFE) $display("FAIL preload got=%h exp=fffe", issue_count); else passed++;
        for (int k = 0; k < 3; k++) step(p);
        checks++; if (issue_count !== 16'h0001) $display("FAIL wrap got=%h exp=0001", issue_count); else passed++;
        fifo_valid = 4'hF;
        rst_n      = 1'b0;
        step(p);
        checks++;
        if (p !== 4'h0 || issue_valid !== 1'b0 || issue_count !== 16'h0)
            $display("FAIL midreset pop=%h valid=%b count=%h exp 0/0/0", p, issue_valid, issue_count);
        else passed++;
        rst_n = 1'b1;
        step(p);
        checks++;
        if (p !== 4'b0001 || issue_wid !== 2'd0 || issue_data !== 32'h70)
            $display("FAIL midreset_grant pop=%h wid=%0d data=%h exp 1/0/70", p, issue_wid, issue_data);
        else passed++;
    endtask

    task automatic test_pop_safety();
        checks++; if (bad_pop !== 0) $display("FAIL pop_empty got=%0d exp=0", bad_pop); else passed++;
    endtask

    initial begin
        rst_n       = 1'b0;
        fifo_valid  = 4'h0;
        fifo_data   = '0;
        warp_enable = 4'h0;
        warp_stall  = 4'h0;
        issue_ready = 1'b0;
        halt_req    = 1'b0;
        clear_model();
        test_reset();
        test_round_robin();
        test_backpressure();
        test_stall_enable();
        test_halt();
        test_pop_safety();
        test_wrap_and_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/warp_issue_scheduler.md
# warp_issue_scheduler

Round-robin issue scheduler that shares one issue port among `NUM_WARPS` per-warp instruction FIFOs. Each cycle it selects one eligible warp, pops that warp's FIFO head and registers the instruction into a single-entry output stage, which drives a valid/ready handshake to the decode/issue stage. It sits between the per-warp instruction FIFO bank and decode. It also provides a drain/halt sequence so the core controller can quiesce issue, for example before a context switch.

## Interface
Parameters:
- `NUM_WARPS`, default 4: number of warps and FIFOs; a power of two, at least 2.
- `DATA_WIDTH`, default 32: instruction width.
- `WID_W`, default `$clog2(NUM_WARPS)`: warp-ID width. Derived; never overridden.

Ports (clock and reset first):
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, **synchronous, active-low**. It is sampled on the rising edge of `clk`.
- `fifo_valid`, in, NUM_WARPS: per-warp FIFO non-empty flag (FIFO `valid`).
- `fifo_data`, in, NUM_WARPS*DATA_WIDTH: per-warp FIFO head data (FIFO `data_out`). Warp w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
- `fifo_pop`, out, NUM_WARPS: one-hot pop strobe to the FIFOs. Combinational.
- `warp_enable`, in, NUM_WARPS: the warp is active and may be scheduled.
- `warp_stall`, in, NUM_WARPS: the warp is blocked this cycle (scoreboard or barrier).
- `issue_valid`, out, 1: the output stage holds an instruction.
- `issue_data`, out, DATA_WIDTH: the held instruction.
- `issue_wid`, out, WID_W: the warp ID of the held instruction.
- `issue_ready`, in, 1: the downstream stage accepts the instruction.
- `halt_req`, in, 1: level request to stop issuing.
- `halted`, out, 1: the scheduler is quiesced.
- `issue_count`, out, 16: number of accepted issues. Wraps modulo 2^16.

## Operation
Eligibility and selection:
- Eligibility is `elig[w] = fifo_valid[w] & warp_enable[w] & ~warp_stall[w]`. It is evaluated combinationally in the current cycle.
- The output slot is free when `!issue_valid || (issue_valid && issue_ready)`.
- Selection is allowed only when state is RUN, the slot is free and `elig != 0`.

When selection is allowed:
- Pick the first eligible warp searching from `last_grant+1` upward, wrapping modulo NUM_WARPS.
- Assert `fifo_pop[sel]` for that cycle.
- At the next edge, load `issue_data <= fifo_data[sel]`, `issue_wid <= sel`, `issue_valid <= 1` and `last_grant <= sel`.
- The FIFO head is captured in the same cycle it is popped.

Otherwise:
- `fifo_pop = 0`.
- If `issue_valid && issue_ready`, the next edge clears `issue_valid`. Otherwise the output stage holds.
- While `issue_valid && !issue_ready`, `issue_data` and `issue_wid` stay stable.

Issue counter:
- `issue_count` increments by 1 on every cycle where `issue_valid && issue_ready`. 0xFFFF wraps to 0x0000.

State machine (2-bit encoding):
- RUN: normal scheduling. When `halt_req=1` it goes to DRAIN in the same cycle, and no pop occurs in that cycle.
- DRAIN: no new selection. The held instruction completes normally.
  - Goes to HALTED when `!issue_valid`, or when `issue_valid && issue_ready`. In the second case `issue_valid` clears on the same edge.
  - Goes back to RUN if `halt_req` drops before then.
- HALTED: `halted=1` and no pops. Goes to RUN the cycle after `halt_req=0`.

Reset (synchronous, active-low):
- On reset: `issue_valid=0`, `issue_data=0`, `issue_wid=0`, `halted=0`, `issue_count=0`, state RUN.
- `last_grant` resets to NUM_WARPS-1, so warp 0 has first priority.
- `fifo_pop` is forced to 0 while `rst_n=0`.
- Reset mid-operation discards the held instruction. Popped FIFO entries are not restored.

## Timing
- Latency: a FIFO head that is eligible in cycle N appears on `issue_*` in cycle N+1.
- Throughput: one instruction per cycle while `issue_ready=1` and some warp is eligible.
- There are no combinational paths from `issue_ready` to `issue_data`.
- `fifo_pop` depends combinationally on `fifo_valid`, `warp_enable`, `warp_stall`, `issue_valid`, `issue_ready` and state.
- `halted` is registered. It asserts the cycle after the DRAIN→HALTED transition condition holds.
- Boundary conditions:
  - A single eligible warp is granted back-to-back every cycle.
  - A warp stalled in a cycle is never popped in that cycle.
  - `fifo_pop[w]` is never asserted when `fifo_valid[w]=0`.

## Test plan
- Round-robin: warps 0-3 each hold 2 instructions (0xA0+w, 0xB0+w), `issue_ready=1`. Required `issue_wid` sequence: 0,1,2,3,0,1,2,3 on consecutive cycles. `issue_count` reaches 8.
- Backpressure: hold `issue_ready=0` for 3 cycles with instruction 0x1234 held. `issue_data` stays 0x1234, `fifo_pop` stays 0, and `issue_count` does not change.
- Stall/enable: `warp_stall=4'b0010`, `warp_enable=4'b1011`, all FIFOs non-empty. Only warps 0 and 3 issue, alternating 0,3,0,3.
- Halt: raise `halt_req` while 0x55 is held and `issue_ready=0`. State goes to DRAIN with no pops. Releasing `issue_ready` accepts 0x55, then `halted=1` one cycle later. Dropping `halt_req` resumes issue at warp (last_grant+1).
- Wrap and reset:
  - Preload `issue_count`=0xFFFE, then do 3 accepts. `issue_count` reads 0x0001.
  - Assert `rst_n=0` for one edge while `issue_valid=1`. The next cycle shows `issue_valid=0` and `issue_count=0`, and the next grant goes to warp 0.
